// File: rtl/i2c_cfg_arbiter.sv
// Sequences the codec boot table and runtime register writes onto one byte-write I2C engine; I2C_CFG_RETRY_EN adds NACK retries.
// One wr_req per write, held until wr_done then low one cycle; runtime writes back-pressure via rt_ready while the holding slot is full.
module i2c_cfg_arbiter #(
  parameter logic [6:0] SLAVE_ADDR = 7'h40,
  parameter int         NUM_INIT   = 7,
  parameter int         RETRY_MAX  = 3
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       init_start,
  output logic       init_done,
  output logic       init_err,
  input  logic       rt_valid,
  input  logic [7:0] rt_addr,
  input  logic [7:0] rt_data,
  output logic       rt_ready,
  output logic       rt_err,
  output logic       busy,
  output logic       wr_req,
  output logic [6:0] wr_dev,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_done,
  input  logic       wr_nack
);

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } cfg_entry_t;

  typedef enum logic [2:0] {
    IDLE, INIT_ISSUE, INIT_WAIT, RT_ISSUE, RT_WAIT, GAP
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_INIT - 1);

  function automatic cfg_entry_t boot_entry(input logic [3:0] i);
    case (i)
      4'd0:    boot_entry = '{addr: 8'h1D, data: 8'h00};
      4'd1:    boot_entry = '{addr: 8'h1A, data: 8'h11};
      4'd2:    boot_entry = '{addr: 8'h03, data: 8'h00};
      4'd3:    boot_entry = '{addr: 8'h04, data: 8'h82};
      4'd4:    boot_entry = '{addr: 8'h01, data: 8'h00};
      4'd5:    boot_entry = '{addr: 8'h02, data: 8'h03};
      4'd6:    boot_entry = '{addr: 8'h00, data: 8'h02};
      default: boot_entry = '0;
    endcase
  endfunction

  state_t     state;
  state_t     gap_next;
  logic [3:0] idx;
  logic       init_pend;
  logic       hold_full;
  cfg_entry_t hold;
  logic       retry_ok;
  logic       pend_window;

  assign wr_dev   = SLAVE_ADDR;
  assign rt_ready = ~hold_full;

  // A GAP that continues the boot sequence is still part of init, so init_start is ignored there.
  assign pend_window = (state == RT_ISSUE) || (state == RT_WAIT) ||
                       ((state == GAP) && (gap_next != INIT_ISSUE));

`ifdef I2C_CFG_RETRY_EN
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  logic [RW-1:0] retry_cnt;

  assign retry_ok = (retry_cnt != RW'(RETRY_MAX));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
    end else if (state == IDLE) begin
      retry_cnt <= '0;
    end else if (((state == INIT_WAIT) || (state == RT_WAIT)) && wr_done) begin
      retry_cnt <= (wr_nack && retry_ok) ? retry_cnt + 1'b1 : '0;
    end
  end
`else
  // RETRY_MAX has no effect without retries.
  logic unused_retry_cfg;
  assign unused_retry_cfg = ^RETRY_MAX;
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gap_next  <= IDLE;
      wr_req    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      init_done <= 1'b0;
      init_err  <= 1'b0;
      rt_err    <= 1'b0;
      busy      <= 1'b0;
      idx       <= '0;
      init_pend <= 1'b0;
      hold_full <= 1'b0;
      hold      <= '0;
    end else begin
      rt_err <= 1'b0;
      if (rt_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold      <= '{addr: rt_addr, data: rt_data};
      end
      if (init_start && pend_window) init_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (init_start || init_pend) begin
            state     <= INIT_ISSUE;
            busy      <= 1'b1;
            idx       <= '0;
            init_pend <= 1'b0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
          end else if (hold_full) begin
            state <= RT_ISSUE;
            busy  <= 1'b1;
          end
        end
        INIT_ISSUE: begin
          wr_req             <= 1'b1;
          {wr_addr, wr_data} <= boot_entry(idx);
          state              <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (wr_done) begin
            wr_req <= 1'b0;
            state  <= GAP;
            if (wr_nack && retry_ok) begin
              gap_next <= INIT_ISSUE;
            end else if (wr_nack) begin
              init_err <= 1'b1;
              gap_next <= IDLE;
            end else if (idx == LAST_IDX) begin
              init_done <= 1'b1;
              gap_next  <= IDLE;
            end else begin
              idx      <= idx + 4'd1;
              gap_next <= INIT_ISSUE;
            end
          end
        end
        RT_ISSUE: begin
          wr_req             <= 1'b1;
          {wr_addr, wr_data} <= hold;
          state              <= RT_WAIT;
        end
        RT_WAIT: begin
          if (wr_done) begin
            wr_req <= 1'b0;
            state  <= GAP;
            if (wr_nack && retry_ok) begin
              gap_next <= RT_ISSUE;
            end else begin
              hold_full <= 1'b0;
              rt_err    <= wr_nack;
              gap_next  <= IDLE;
            end
          end
        end
        // Back-to-back writes re-request straight from GAP so wr_req is low for exactly one cycle.
        GAP: begin
          case (gap_next)
            INIT_ISSUE: begin
              wr_req             <= 1'b1;
              {wr_addr, wr_data} <= boot_entry(idx);
              state              <= INIT_WAIT;
            end
            RT_ISSUE: begin
              wr_req             <= 1'b1;
              {wr_addr, wr_data} <= hold;
              state              <= RT_WAIT;
            end
            default: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          endcase
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          wr_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// Randomized scoreboard bench for i2c_cfg_arbiter: a write-list model feeds expected writes and engine responses,
// while a monitor checks every wr_req transaction in order and an engine model answers with random latency.
module tb_i2c_cfg_arbiter;

  localparam int NUM_INIT  = 7;
  localparam int RETRY_MAX = 3;
`ifdef I2C_CFG_RETRY_EN
  localparam int R = RETRY_MAX;
`else
  localparam int R = 0;
`endif

  logic       sys_clk = 1'b0;
  logic       rst_n, init_start, rt_valid, wr_done, wr_nack;
  logic [7:0] rt_addr, rt_data;
  logic       init_done, init_err, rt_ready, rt_err, busy, wr_req;
  logic [6:0] wr_dev;
  logic [7:0] wr_addr, wr_data;

  i2c_cfg_arbiter #(.SLAVE_ADDR(7'h40), .NUM_INIT(NUM_INIT), .RETRY_MAX(RETRY_MAX)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .init_start(init_start), .init_done(init_done),
    .init_err(init_err), .rt_valid(rt_valid), .rt_addr(rt_addr), .rt_data(rt_data),
    .rt_ready(rt_ready), .rt_err(rt_err), .busy(busy), .wr_req(wr_req), .wr_dev(wr_dev),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done), .wr_nack(wr_nack)
  );

  initial forever #5 sys_clk = ~sys_clk;

  logic [15:0] boot_tbl [0:6] = '{16'h1D00, 16'h1A11, 16'h0300, 16'h0482, 16'h0100, 16'h0203, 16'h0002};

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  bit          resp_q[$];
  int          gap_q[$];
  int          seen = 0;
  int          rt_err_cnt = 0;
  bit          stray = 0;
  bit          exp_done = 0;
  bit          exp_err = 0;
  int          nk[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Engine model: answers each request after 0..3 idle cycles using the planned ACK/NACK list.
  initial begin
    bit active = 0;
    int lat = 0;
    wr_done = 1'b0;
    wr_nack = 1'b0;
    forever begin
      @(negedge sys_clk);
      wr_done = 1'b0;
      wr_nack = 1'b0;
      if (stray) begin
        wr_done = 1'b1;
        stray = 0;
      end else if (rst_n && wr_req) begin
        if (!active) begin
          active = 1;
          lat = $urandom_range(0, 3);
        end
        if (lat == 0) begin
          wr_done = 1'b1;
          wr_nack = (resp_q.size() > 0) ? resp_q.pop_front() : 1'b0;
          active = 0;
        end else begin
          lat--;
        end
      end else begin
        active = 0;
      end
    end
  end

  // Monitor: scoreboard compare on each rising wr_req, plus stability, gap and rt_err pulse tracking.
  initial begin
    bit prev = 0, have_prev = 0, prev_err = 0;
    int low = 0;
    logic [15:0] cur = '0;
    forever begin
      @(negedge sys_clk);
      if (!rst_n) begin
        prev = 0; have_prev = 0; low = 0; prev_err = 0;
      end else begin
        if (wr_req && !prev) begin
          seen++;
          cur = {wr_addr, wr_data};
          if (have_prev) gap_q.push_back(low);
          have_prev = 1;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got 0x%0h expected no write", cur);
          end else begin
            check("write_order", cur, exp_q.pop_front());
          end
          check("wr_dev", wr_dev, 7'h40);
        end else if (wr_req && ({wr_addr, wr_data} !== cur)) begin
          check("wr_stable", {wr_addr, wr_data}, cur);
        end
        if (wr_req) low = 0; else low++;
        if (rt_err) begin
          rt_err_cnt++;
          check("rt_err_width", prev_err, 0);
        end
        prev = wr_req;
        prev_err = rt_err;
      end
    end
  end

  task automatic send_rt(input logic [7:0] a, input logic [7:0] d);
    bit acc = 0;
    rt_valid = 1'b1; rt_addr = a; rt_data = d;
    for (int i = 0; i < 2000 && !acc; i++) begin
      acc = rt_ready;
      @(negedge sys_clk);
    end
    rt_valid = 1'b0;
    check("rt_accept", acc, 1);
    check("rt_ready_full", rt_ready, 0);
  endtask

  // rt_mode: 0 none, 1 during init after k writes (k=0: random), 2 captured just before init_start, 3 runtime only.
  task automatic run_case(input bit do_init, input int rt_mode, input logic [7:0] a, input logic [7:0] d,
                          input int rt_n, input int k_in);
    int  total = 0, k, base, exp_rt_err = 0;
    bit  fail = 0, ok = 0;
    exp_q.delete(); resp_q.delete(); gap_q.delete(); rt_err_cnt = 0;
    if (do_init) begin
      for (int e = 0; e < NUM_INIT && !fail; e++) begin
        int att;
        att = ((nk[e] < R) ? nk[e] : R) + 1;
        for (int t = 0; t < att; t++) begin
          exp_q.push_back(boot_tbl[e]);
          resp_q.push_back(t < nk[e]);
          total++;
        end
        if (nk[e] > R) fail = 1;
      end
      exp_done = !fail;
      exp_err = fail;
    end
    if (rt_mode != 0) begin
      int att;
      att = ((rt_n < R) ? rt_n : R) + 1;
      for (int t = 0; t < att; t++) begin
        exp_q.push_back({a, d});
        resp_q.push_back(t < rt_n);
      end
      exp_rt_err = (rt_n > R) ? 1 : 0;
    end
    base = seen;
    if (rt_mode == 2 || rt_mode == 3) send_rt(a, d);
    if (do_init) begin
      if (rt_mode != 2) @(negedge sys_clk);
      init_start = 1'b1;
      @(negedge sys_clk);
      init_start = 1'b0;
      check("init_done_cleared", init_done, 0);
      check("init_err_cleared", init_err, 0);
    end
    if (rt_mode == 1) begin
      k = (k_in > 0) ? k_in : $urandom_range(1, total);
      for (int i = 0; i < 3000 && (seen - base) < k; i++) @(negedge sys_clk);
      check("rt_inject_wait", ((seen - base) >= k) ? 1 : 0, 1);
      send_rt(a, d);
    end
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      if (!busy && rt_ready && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check("complete", ok, 1);
    repeat (3) @(negedge sys_clk);
    check("init_done", init_done, exp_done);
    check("init_err", init_err, exp_err);
    check("rt_err_count", rt_err_cnt, exp_rt_err);
    check("rt_ready_end", rt_ready, 1);
    check("busy_end", busy, 0);
    check("writes_left", exp_q.size(), 0);
  endtask

  initial begin
    bit hit = 0;
    rst_n = 1'b0; init_start = 1'b0; rt_valid = 1'b0; rt_addr = '0; rt_data = '0;
    repeat (3) @(negedge sys_clk);
    check("rst_wr_req", wr_req, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_init_done", init_done, 0);
    check("rst_init_err", init_err, 0);
    check("rst_rt_err", rt_err, 0);
    check("rst_busy", busy, 0);
    check("rst_rt_ready", rt_ready, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Full boot sequence, all ACKed: table order with a single idle cycle between writes.
    for (int e = 0; e < 16; e++) nk[e] = 0;
    run_case(1, 0, 8'h00, 8'h00, 0, 0);
    check("gap_count", gap_q.size(), NUM_INIT - 1);
    foreach (gap_q[i]) check("gap_len", gap_q[i], 1);

    // Runtime write arriving during entry 2 waits for the whole init sequence.
    run_case(1, 1, 8'h05, 8'h3C, 0, 3);

    // NACKs on entry 3: one and two of them.
    nk[3] = 1;
    run_case(1, 0, 8'h00, 8'h00, 0, 0);
    nk[3] = 2;
    run_case(1, 0, 8'h00, 8'h00, 0, 0);
    nk[3] = 0;

    // init_start coinciding with a full holding register: init first.
    run_case(1, 2, 8'hA7, 8'h19, 0, 0);

    // Runtime-only writes: ACK, then exhausted NACKs.
    run_case(0, 3, 8'h22, 8'h5A, 0, 0);
    run_case(0, 3, 8'h23, 8'h5B, R + 1, 0);

    // Reset mid-write on entry 4, stray wr_done afterwards, then a clean restart.
    exp_q.delete(); resp_q.delete();
    for (int t = 0; t < NUM_INIT; t++) exp_q.push_back(boot_tbl[t]);
    @(negedge sys_clk);
    init_start = 1'b1;
    @(negedge sys_clk);
    init_start = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      if (wr_req && wr_addr == 8'h01) hit = 1;
      else @(negedge sys_clk);
    end
    check("entry4_seen", hit, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_wr_req", wr_req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_init_done", init_done, 0);
    exp_q.delete(); resp_q.delete();
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
    stray = 1;
    repeat (4) @(negedge sys_clk);
    check("stray_wr_req", wr_req, 0);
    check("stray_busy", busy, 0);
    check("post_rst_init_done", init_done, 0);
    exp_done = 0; exp_err = 0;
    run_case(1, 0, 8'h00, 8'h00, 0, 0);

    // Randomized NACK patterns and runtime injection points.
    for (int it = 0; it < 16; it++) begin
      for (int e = 0; e < 16; e++) nk[e] = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0;
      run_case(1, $urandom_range(0, 2), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
